// File: rtl/ds_converter.sv
// Digital-to-stochastic converter: turns a PRECISION-bit value into a 2^PRECISION-bit
// unipolar bitstream whose count of ones equals the value exactly, framed by `last`.
module ds_converter #(
    parameter int PRECISION = 8,
    parameter int RNG_MODE  = 0,
    parameter int SEED      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRECISION-1:0] in_value,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 hold,
    output logic                 out,
    output logic                 out_valid,
    output logic                 last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Maximal-length Fibonacci feedback taps, bit (t-1) set for tap t.
    function automatic logic [15:0] tap_mask(input int p);
        logic [15:0] m;
        case (p)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam logic [15:0]          TAP_ALL  = tap_mask(PRECISION);
    localparam logic [PRECISION-1:0] TAPS     = TAP_ALL[PRECISION-1:0];
    localparam logic [PRECISION-1:0] IDX_LAST = '1;
    localparam logic [PRECISION-1:0] IDX_ONE  = {{(PRECISION-1){1'b0}}, 1'b1};
    localparam logic [PRECISION-1:0] SEED_VAL = SEED[PRECISION-1:0];

    if (PRECISION < 3 || PRECISION > 16) begin : g_bad_precision
        $error("ds_converter: PRECISION must be within 3..16");
    end

    state_t                 state_reg, state_next;
    logic [PRECISION-1:0]   idx_reg, idx_next;
    logic [PRECISION-1:0]   lfsr_reg, lfsr_next;
    logic [PRECISION-1:0]   value_reg, value_next;
    logic                   out_reg, out_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   last_reg, last_next;

    logic [PRECISION-1:0]   idx_rev;
    logic [PRECISION-1:0]   lfsr_step;
    logic [PRECISION-1:0]   rnd;
    logic                   at_last;
    logic                   accept;

    for (genvar gi = 0; gi < PRECISION; gi++) begin : g_rev
        assign idx_rev[gi] = idx_reg[PRECISION-1-gi];
    end

    assign lfsr_step = {lfsr_reg[PRECISION-2:0], ^(lfsr_reg & TAPS)};

    // In LFSR mode index 0 supplies the all-zero value the LFSR never reaches,
    // so every value 0..2^PRECISION-1 appears exactly once per stream.
    assign rnd = (RNG_MODE == 0) ? idx_rev
               : ((idx_reg == '0) ? '0 : lfsr_reg);

    assign at_last  = (idx_reg == IDX_LAST);
    assign in_ready = rst && ((state_reg == IDLE) ||
                              (state_reg == RUN && at_last && !hold));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        lfsr_next      = lfsr_reg;
        value_next     = value_reg;
        out_next       = 1'b0;
        out_valid_next = 1'b0;
        last_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    value_next = in_value;
                    idx_next   = '0;
                    lfsr_next  = SEED_VAL;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    out_next       = (rnd < value_reg);
                    out_valid_next = 1'b1;
                    last_next      = at_last;
                    if (at_last) begin
                        if (accept) begin
                            value_next = in_value;
                            idx_next   = '0;
                            lfsr_next  = SEED_VAL;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_ONE;
                        if (idx_reg != '0) begin
                            lfsr_next = lfsr_step;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            lfsr_reg      <= SEED_VAL;
            value_reg     <= '0;
            out_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            lfsr_reg      <= lfsr_next;
            value_reg     <= value_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            last_reg      <= last_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign last      = last_reg;

endmodule

// File: tb/tb_ds_converter.sv
// Bench for ds_converter: bit-reversed and LFSR instances at PRECISION=8 plus a
// small LFSR instance at PRECISION=4, checked against a value-level stream model.
module tb_ds_converter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] iv   [3];
    logic       ivld [3];
    logic       hld  [3];
    logic       rdy  [3];
    logic       o    [3];
    logic       ov   [3];
    logic       lst  [3];

    int cmp = 0;
    int err = 0;

    bit hold_edge [3];
    bit bits_q [3][$];
    int last_cnt [3];
    int last_at  [3];

    always #5 clk = ~clk;

    ds_converter #(.PRECISION(8), .RNG_MODE(0), .SEED(1)) dut0 (
        .clk(clk), .rst(rst), .in_value(iv[0]), .in_valid(ivld[0]), .in_ready(rdy[0]),
        .hold(hld[0]), .out(o[0]), .out_valid(ov[0]), .last(lst[0]));

    ds_converter #(.PRECISION(8), .RNG_MODE(1), .SEED(1)) dut1 (
        .clk(clk), .rst(rst), .in_value(iv[1]), .in_valid(ivld[1]), .in_ready(rdy[1]),
        .hold(hld[1]), .out(o[1]), .out_valid(ov[1]), .last(lst[1]));

    ds_converter #(.PRECISION(4), .RNG_MODE(1), .SEED(5)) dut2 (
        .clk(clk), .rst(rst), .in_value(iv[2][3:0]), .in_valid(ivld[2]), .in_ready(rdy[2]),
        .hold(hld[2]), .out(o[2]), .out_valid(ov[2]), .last(lst[2]));

    task automatic check(input string name, input longint act, input longint exp);
        cmp++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected bit k of a bit-reversed-counter stream: ones where reverse(k) < v.
    function automatic bit model_bit(input int k, input int v, input int p);
        int r = 0;
        for (int b = 0; b < p; b++) begin
            if (((k >> b) & 1) != 0) r |= (1 << (p - 1 - b));
        end
        return (r < v);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) hold_edge[d] <= hld[d];
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d]) bits_q[d].push_back(o[d]);
            if (lst[d]) begin
                last_cnt[d]++;
                last_at[d] = bits_q[d].size();
                check("last_with_valid", ov[d], 1);
            end
            if (hold_edge[d]) check("hold_no_valid", ov[d], 0);
        end
    end

    task automatic run_stream(input int d, input int v, input int hold_pct);
        int guard;
        bits_q[d].delete();
        last_cnt[d] = 0;
        @(negedge clk);
        iv[d]   = 8'(v);
        ivld[d] = 1'b1;
        hld[d]  = 1'b0;
        guard   = 0;
        while (!rdy[d] && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        ivld[d] = 1'b0;
        guard   = 0;
        while (last_cnt[d] == 0 && guard < 3000) begin
            hld[d] = ($urandom_range(99) < 32'(hold_pct));
            @(negedge clk);
            guard++;
        end
        hld[d] = 1'b0;
        $display("stream dut%0d value=%0d hold%%=%0d bits=%0d lasts=%0d", d, v, hold_pct,
                 bits_q[d].size(), last_cnt[d]);
        check("stream_done", last_cnt[d], 1);
    endtask

    task automatic post_check(input int d, input int v, input int len);
        int ones = 0;
        int mism = 0;
        for (int i = 0; i < bits_q[d].size(); i++) begin
            ones += int'(bits_q[d][i]);
            if (d == 0 && bits_q[d][i] != model_bit(i, v, 8)) mism++;
        end
        check("length", bits_q[d].size(), len);
        check("ones", ones, v);
        check("last_position", last_at[d], len);
        if (d == 0) check("sequence", mism, 0);
    endtask

    typedef struct {
        int d;
        int v;
        int hold_pct;
        int exp_ones;
        int exp_len;
        bit exp_first;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int gaps;
        int lastc;
        int ones_a;
        int ones_b;
        int mism;
        bit saved [$];

        tbl[0] = '{0,   0,  0,   0, 256, 1'b0};
        tbl[1] = '{0, 128,  0, 128, 256, 1'b1};
        tbl[2] = '{0, 255,  0, 255, 256, 1'b1};
        tbl[3] = '{1,   1,  0,   1, 256, 1'b1};
        tbl[4] = '{1,  77,  0,  77, 256, 1'b1};
        tbl[5] = '{1, 200,  0, 200, 256, 1'b1};
        tbl[6] = '{2,  15, 20,  15,  16, 1'b1};
        tbl[7] = '{2,   0, 20,   0,  16, 1'b0};
        tbl[8] = '{0, 100, 30, 100, 256, 1'b1};

        for (int d = 0; d < 3; d++) begin
            iv[d] = '0; ivld[d] = 1'b0; hld[d] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready", rdy[0], 0);
        check("reset_valid", ov[0], 0);
        check("reset_last", lst[0], 0);
        check("reset_out", o[1], 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", rdy[0], 1);
        $display("reset released ready=%0d", rdy[0]);

        // Value 0: exact framing and in_ready timing
        @(negedge clk);
        iv[0] = 8'd0; ivld[0] = 1'b1;
        @(negedge clk);
        ivld[0] = 1'b0;
        check("first_cycle_no_valid", ov[0], 0);
        ones_a = 0;
        for (int c = 1; c <= 257; c++) begin
            @(negedge clk);
            if (c <= 256) ones_a += int'(o[0]);
            if (c == 1)   check("first_bit_valid", ov[0], 1);
            if (c == 254) check("ready_mid_stream", rdy[0], 0);
            if (c == 255) check("ready_on_final_idx", rdy[0], 1);
            if (c == 255) check("no_early_last", lst[0], 0);
            if (c == 256) check("last_on_256th", lst[0], 1);
            if (c == 257) check("idle_after_stream", ov[0], 0);
        end
        check("zero_ones", ones_a, 0);
        $display("value0 stream ones=%0d", ones_a);

        // Table-driven streams
        for (int t = 0; t < 9; t++) begin
            run_stream(tbl[t].d, tbl[t].v, tbl[t].hold_pct);
            post_check(tbl[t].d, tbl[t].exp_ones, tbl[t].exp_len);
            if (bits_q[tbl[t].d].size() > 0)
                check("first_bit", bits_q[tbl[t].d][0], tbl[t].exp_first);
        end

        // LFSR restarts from the seed: same value twice gives the same stream
        run_stream(1, 77, 0);
        saved = bits_q[1];
        run_stream(1, 77, 25);
        mism = 0;
        for (int i = 0; i < saved.size() && i < bits_q[1].size(); i++)
            if (saved[i] != bits_q[1][i]) mism++;
        check("seed_reload_repeat", mism, 0);

        // Back-to-back 10 then 20 with in_valid held
        bits_q[0].delete(); last_cnt[0] = 0;
        @(negedge clk);
        iv[0] = 8'd10; ivld[0] = 1'b1;
        @(negedge clk);
        iv[0] = 8'd20;
        gaps = 0;
        for (int c = 1; c <= 512; c++) begin
            @(negedge clk);
            if (c == 255) check("b2b_ready", rdy[0], 1);
            if (c == 256) ivld[0] = 1'b0;
            if (!ov[0]) gaps++;
        end
        @(negedge clk);
        check("b2b_end_idle", ov[0], 0);
        check("b2b_gaps", gaps, 0);
        check("b2b_last_count", last_cnt[0], 2);
        check("b2b_length", bits_q[0].size(), 512);
        ones_a = 0; ones_b = 0; mism = 0;
        for (int i = 0; i < bits_q[0].size(); i++) begin
            if (i < 256) ones_a += int'(bits_q[0][i]);
            else         ones_b += int'(bits_q[0][i]);
            if (bits_q[0][i] != model_bit(i % 256, (i < 256) ? 10 : 20, 8)) mism++;
        end
        check("b2b_ones_first", ones_a, 10);
        check("b2b_ones_second", ones_b, 20);
        check("b2b_sequence", mism, 0);
        $display("back-to-back ones=%0d,%0d gaps=%0d", ones_a, ones_b, gaps);

        // Hold for 5 cycles at idx 50 of value 100
        bits_q[0].delete(); last_cnt[0] = 0;
        @(negedge clk);
        iv[0] = 8'd100; ivld[0] = 1'b1;
        @(negedge clk);
        ivld[0] = 1'b0;
        gaps = 0; lastc = -1;
        for (int c = 1; c <= 262; c++) begin
            @(negedge clk);
            if (!ov[0] && c <= 261) gaps++;
            if (lst[0] && lastc < 0) lastc = c;
            hld[0] = (c >= 50 && c <= 54);
        end
        hld[0] = 1'b0;
        check("hold_gap_cycles", gaps, 5);
        check("hold_last_cycle", lastc, 261);
        post_check(0, 100, 256);
        $display("hold stream gaps=%0d last_cycle=%0d", gaps, lastc);

        // Reset mid-stream at idx 120
        bits_q[0].delete(); last_cnt[0] = 0;
        @(negedge clk);
        iv[0] = 8'd200; ivld[0] = 1'b1;
        @(negedge clk);
        ivld[0] = 1'b0;
        repeat (120) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_valid", ov[0], 0);
        check("midreset_last", lst[0], 0);
        check("midreset_ready", rdy[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("after_reset_ready", rdy[0], 1);
        check("after_reset_valid", ov[0], 0);
        check("abandoned_no_last", last_cnt[0], 0);
        run_stream(0, 37, 0);
        post_check(0, 37, 256);

        // Randomized streams
        for (int n = 0; n < 6; n++) begin
            int d;
            int v;
            d = int'($urandom_range(2));
            v = (d == 2) ? int'($urandom_range(15)) : int'($urandom_range(255));
            run_stream(d, v, int'($urandom_range(40)));
            post_check(d, v, (d == 2) ? 16 : 256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
